// File: rtl/lif_spike_monitor.sv
// lif_spike_monitor
//
// Watches the spike line and 8-bit membrane state of a LIF neuron and
// reports per-window statistics: spike count (rising edges only), peak
// membrane state and a burst flag. Results are registered one cycle after
// the last cycle of each window and held until the next window closes.
//
// Optional feature: define SPIKE_ISI_EN to add inter-spike interval
// measurement. Without it, isi and isi_valid are tied to zero and no ISI
// registers exist.
//
// Ports
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      1 = monitor runs, 0 = everything frozen
//   spike_in    in   1      neuron spike output
//   state_in    in   8      neuron membrane state, unsigned
//   rate        out  CNT_W  spike count of last completed window
//   peak        out  8      max state_in of last completed window
//   burst       out  1      rate >= BURST_THR for last completed window
//   rate_valid  out  1      one-cycle pulse when rate/peak/burst update
//   isi         out  CNT_W  last inter-spike interval in cycles
//   isi_valid   out  1      one-cycle pulse when isi updates

module lif_spike_monitor #(
   parameter int WIN_CYCLES = 256,
   parameter int CNT_W      = 8,
   parameter int BURST_THR  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             spike_in,
   input  logic [7:0]       state_in,
   output logic [CNT_W-1:0] rate,
   output logic [7:0]       peak,
   output logic             burst,
   output logic             rate_valid,
   output logic [CNT_W-1:0] isi,
   output logic             isi_valid
);

   localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic             inc);
      if (a == CNT_MAX) return CNT_MAX;
      return a + CNT_W'(inc);
   endfunction

   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] spike_cnt;
   logic [7:0]       peak_acc;
   logic             spike_d;

   logic             spike_evt;
   logic             win_final;
   logic [CNT_W-1:0] cnt_next;
   logic [7:0]       peak_next;

   // A held spike counts once: only the low-to-high transition is an event.
   assign spike_evt = spike_in & ~spike_d;
   assign win_final = (win_cnt == WIN_LAST);
   // The final window cycle's own event and state are folded into the result.
   assign cnt_next  = sat_add(spike_cnt, spike_evt);
   assign peak_next = max8(peak_acc, state_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt    <= '0;
         spike_cnt  <= '0;
         peak_acc   <= '0;
         spike_d    <= 1'b0;
         rate       <= '0;
         peak       <= '0;
         burst      <= 1'b0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (en) begin
            spike_d <= spike_in;
            if (win_final) begin
               win_cnt    <= '0;
               rate       <= cnt_next;
               peak       <= peak_next;
               burst      <= (32'(cnt_next) >= BURST_THR);
               rate_valid <= 1'b1;
               spike_cnt  <= '0;
               peak_acc   <= '0;
            end else begin
               win_cnt   <= win_cnt + 1'b1;
               spike_cnt <= cnt_next;
               peak_acc  <= peak_next;
            end
         end
      end
   end

`ifdef SPIKE_ISI_EN
   logic [CNT_W-1:0] isi_cnt;
   logic             isi_armed;

   // isi_cnt restarts at 1 on each event so that, at the next event, it
   // holds the number of enabled cycles between the two edges. The first
   // event after reset has no predecessor and only arms the measurement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_cnt   <= '0;
         isi_armed <= 1'b0;
         isi       <= '0;
         isi_valid <= 1'b0;
      end else begin
         isi_valid <= 1'b0;
         if (en) begin
            if (spike_evt) begin
               isi_cnt   <= CNT_W'(1);
               isi_armed <= 1'b1;
               if (isi_armed) begin
                  isi       <= isi_cnt;
                  isi_valid <= 1'b1;
               end
            end else begin
               isi_cnt <= sat_add(isi_cnt, 1'b1);
            end
         end
      end
   end
`else
   assign isi       = '0;
   assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Self-checking bench for lif_spike_monitor (default parameters).
// Compile with +define+SPIKE_ISI_EN to also check ISI measurement.

module tb_lif_spike_monitor;

   localparam int WIN  = 256;
   localparam int CMAX = 255;
   localparam int THR  = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       spike_in = 1'b0;
   logic [7:0] state_in = 8'd0;
   logic [7:0] rate, peak, isi;
   logic       burst, rate_valid, isi_valid;

   int total = 0;
   int bad   = 0;

   // Reference model state: enabled-cycle timestamps and window tallies.
   int m_idx, m_cnt, m_peak, m_last;
   bit m_prev;
   int e_rate, e_peak, e_burst, e_rv, e_isi, e_iv;

   lif_spike_monitor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .spike_in   (spike_in),
      .state_in   (state_in),
      .rate       (rate),
      .peak       (peak),
      .burst      (burst),
      .rate_valid (rate_valid),
      .isi        (isi),
      .isi_valid  (isi_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_cnt = 0; m_peak = 0; m_last = -1; m_prev = 0;
      e_rate = 0; e_peak = 0; e_burst = 0; e_rv = 0; e_isi = 0; e_iv = 0;
   endtask

   // Applies the rules to the inputs present at this clock edge.
   task automatic model_edge();
      bit evt;
      if (!rst_n) begin
         model_reset();
      end else begin
         e_rv = 0;
         e_iv = 0;
         if (en) begin
            evt    = spike_in && !m_prev;
            m_prev = spike_in;
            m_idx++;
            if (evt && m_cnt < CMAX) m_cnt++;
            if (int'(state_in) > m_peak) m_peak = int'(state_in);
            if (m_idx % WIN == 0) begin
               e_rate  = m_cnt;
               e_peak  = m_peak;
               e_burst = (m_cnt >= THR) ? 1 : 0;
               e_rv    = 1;
               m_cnt   = 0;
               m_peak  = 0;
            end
`ifdef SPIKE_ISI_EN
            if (evt) begin
               if (m_last >= 0) begin
                  e_isi = (m_idx - m_last > CMAX) ? CMAX : m_idx - m_last;
                  e_iv  = 1;
               end
               m_last = m_idx;
            end
`endif
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("rate",       int'(rate),       e_rate);
      chk("peak",       int'(peak),       e_peak);
      chk("burst",      int'(burst),      e_burst);
      chk("rate_valid", int'(rate_valid), e_rv);
      chk("isi",        int'(isi),        e_isi);
      chk("isi_valid",  int'(isi_valid),  e_iv);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_async_rate", int'(rate), 0);
      chk("rst_async_rv",   int'(rate_valid), 0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int first_t;
      model_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // Idle window: all zero results, valid after exactly 256 cycles.
      en = 1'b1; spike_in = 1'b0; state_in = 8'd0;
      first_t = -1;
      for (int t = 0; t < WIN; t++) begin
         step();
         if (rate_valid && first_t < 0) first_t = t;
      end
      chk("idle_valid_cycle", first_t, WIN - 1);
      chk("idle_rate", int'(rate), 0);
      chk("idle_burst", int'(burst), 0);

      // One-cycle spike every 8 cycles with a 0..200 state ramp.
      for (int i = 0; i < WIN; i++) begin
         spike_in = (i % 8 == 0);
         state_in = 8'(i * 200 / 255);
         step();
      end
      chk("ramp_rate", int'(rate), 32);
      chk("ramp_peak", int'(peak), 200);
      chk("ramp_burst", int'(burst), 1);

      // Spike held high for a full window counts once.
      state_in = 8'd7;
      for (int i = 0; i < WIN; i++) begin
         spike_in = 1'b1;
         step();
      end
      chk("held_rate", int'(rate), 1);
      chk("held_burst", int'(burst), 0);

      // Edge on the final window cycle belongs to the closing window.
      for (int i = 0; i < WIN; i++) begin
         spike_in = (i == WIN - 1);
         step();
      end
      chk("final_edge_rate", int'(rate), 1);
      for (int i = 0; i < WIN; i++) begin
         spike_in = 1'b0;
         step();
      end
      chk("after_final_rate", int'(rate), 0);
      // Edge on cycle 0 belongs to the new window.
      for (int i = 0; i < WIN; i++) begin
         spike_in = (i == 0);
         step();
      end
      chk("first_edge_rate", int'(rate), 1);

      // Freeze for 100 cycles mid-window: close is delayed by exactly 100.
      first_t = -1;
      for (int t = 0; t < WIN + 100; t++) begin
         en       = !(t >= 100 && t < 200);
         spike_in = (t % 4 == 1);
         state_in = 8'($urandom_range(0, 255));
         step();
         if (rate_valid && first_t < 0) first_t = t;
      end
      chk("freeze_valid_cycle", first_t, WIN + 99);
      chk("freeze_rate", int'(rate), 64);
      en = 1'b1;

      // Randomized traffic: gaps in en, held and toggling spikes.
      for (int t = 0; t < 1500; t++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) spike_in = ~spike_in;
         state_in = 8'($urandom);
         step();
      end

      // Reset mid-window discards the partial window.
      do_reset();
      chk("rst_rate", int'(rate), 0);
      chk("rst_peak", int'(peak), 0);
      en = 1'b1;
      first_t = -1;
      for (int t = 0; t < WIN + 4; t++) begin
         spike_in = ($urandom_range(0, 3) == 0);
         state_in = 8'($urandom);
         step();
         if (rate_valid && first_t < 0) first_t = t;
      end
      chk("rst_valid_cycle", first_t, WIN - 1);

      // ISI: edges at cycles 10, 35 and 335 after reset release.
      spike_in = 1'b0;
      do_reset();
      en = 1'b1;
      for (int t = 0; t < 400; t++) begin
         spike_in = (t == 10 || t == 35 || t == 335);
         state_in = 8'd0;
         step();
`ifdef SPIKE_ISI_EN
         if (t == 10) chk("isi_first_none", int'(isi_valid), 0);
         if (t == 35) begin
            chk("isi_25_valid", int'(isi_valid), 1);
            chk("isi_25", int'(isi), 25);
         end
         if (t == 335) begin
            chk("isi_sat_valid", int'(isi_valid), 1);
            chk("isi_sat", int'(isi), 255);
         end
`else
         if (t == 35) chk("isi_tied", int'(isi), 0);
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
